seg7_scan_rotator: RTL
======================

SEG7_SCAN_ROTATOR -- requirements
Module: seg7_scan_rotator

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 5, meaning the number of 3-bit character channels (2..16).
REQ-002 The block SHALL have parameter NUM_DIGITS, default 4, meaning the number of multiplexed display digits (1..8, NUM_DIGITS <= NUM_CH).
REQ-003 The block SHALL have parameter SCAN_TICKS, default 50000, meaning clock cycles each digit stays enabled (>= 2).
REQ-004 The block SHALL have parameter ROT_TICKS, default 25000000, meaning clock cycles between rotation steps (>= 2).
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port ch_data, input, 3*NUM_CH bits: packed character codes, channel k in bits [3k+2:3k].
REQ-008 Port sel, input, clog2(NUM_CH) bits: manual start channel.
REQ-009 Port rotate, input, 1 bit: 1 selects auto-rotate mode, 0 selects manual mode.
REQ-010 Port pause, input, 1 bit: 1 freezes the rotation timer and offset.
REQ-011 Port seg, output, 7 bits: active-low segments, bit0 = a ... bit6 = g.
REQ-012 Port an, output, NUM_DIGITS bits: active-low one-hot digit enable.

Function
REQ-013 The block SHALL keep an offset register 0..NUM_CH-1; the digit at index d SHALL show channel (offset+d) mod NUM_CH.
REQ-014 The block SHALL decode codes 0=H, 1=E, 2=L, 3=O; codes 4..7 SHALL be blank (seg = 7'h7F).
REQ-015 A scan counter SHALL advance the digit index every SCAN_TICKS cycles, 0..NUM_DIGITS-1, wrapping to 0.
REQ-016 seg and an SHALL be registered and SHALL reflect the current digit index and offset one cycle after they change.
REQ-017 Exactly one an bit SHALL be low in every cycle after the first post-reset edge.
REQ-018 In manual mode the offset SHALL load sel each cycle; sel >= NUM_CH SHALL load 0.
REQ-019 In rotate mode with pause=0, the offset SHALL increment every ROT_TICKS cycles, wrapping from NUM_CH-1 to 0; sel SHALL be ignored.
REQ-020 pause=1 SHALL hold the offset and the rotation timer while scanning continues.
REQ-021 On a 0->1 transition of rotate, the rotation timer SHALL restart at 0 and the offset SHALL continue from its current value.
REQ-022 On a 1->0 transition of rotate, the offset SHALL load sel on the next edge.
REQ-023 A ch_data change SHALL appear on the active digit no more than 1 cycle later.

Reset
REQ-024 While rst_n=0, seg SHALL be 7'h7F, an SHALL be all ones, and offset, digit index, scan counter and rotation timer SHALL be 0.
REQ-025 The first rising edge after rst_n deasserts SHALL drive an[0] low with digit 0's pattern.
REQ-026 Reset asserted mid-scan or mid-rotation SHALL immediately force the REQ-024 values.

Configuration
REQ-027 Macro SEG7_ROTATE_EN SHALL control the rotation feature.
REQ-028 With SEG7_ROTATE_EN defined, REQ-019..REQ-022 SHALL apply.
REQ-029 Without SEG7_ROTATE_EN, the rotation timer SHALL be absent, rotate and pause SHALL be ignored, and the block SHALL behave as manual mode permanently.

Structure
REQ-030 A shared package seg7_pkg SHALL hold the character code constants (H, E, L, O, blank) and the 7-bit segment patterns.
REQ-031 Character decoding SHALL live in sub-module seg7_char_decode, a 3-bit code to 7-bit active-low pattern, instantiated once on the muxed channel.

Verification
All scenarios use NUM_CH=5, NUM_DIGITS=4, SCAN_TICKS=4, ROT_TICKS=16, and ch_data codes {ch4..ch0}={3,2,2,1,0} ("HELLO").
REQ-032 Reset, then release -> an cycles 1110,1101,1011,0111 every 4 clocks, with seg H,E,L,L.
REQ-033 Manual mode, sel=2 -> digits show L,L,O,H; then sel=7 -> offset 0, digits show H,E,L,L.
REQ-034 rotate=1 for 80 cycles -> offset steps 0,1,2,3,4,0 at 16-cycle intervals; the 4->0 wrap is checked.
REQ-035 rotate=1, pause=1 for 40 cycles at offset 3 -> offset stays 3 while an keeps scanning; pause=0 -> next step after the remaining timer count.
REQ-036 rst_n pulsed low mid-digit 2 at offset 3 -> seg=7'h7F and an=1111 asynchronously; after release, an[0] low with pattern H.
REQ-037 Built without SEG7_ROTATE_EN, rotate=1 and sel=1 -> digits show E,L,L,O with no offset change over 64 cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared character codes and active-low 7-segment patterns (bit0 = a ... bit6 = g).
package seg7_pkg;

    localparam logic [2:0] CHAR_H = 3'd0;
    localparam logic [2:0] CHAR_E = 3'd1;
    localparam logic [2:0] CHAR_L = 3'd2;
    localparam logic [2:0] CHAR_O = 3'd3;
    // Codes 4..7 are all blank; CHAR_BLANK is the canonical one.
    localparam logic [2:0] CHAR_BLANK = 3'd4;

    // Active-low: a 0 bit lights the segment.
    localparam logic [6:0] SEG_H     = 7'h09; // b c e f g
    localparam logic [6:0] SEG_E     = 7'h06; // a d e f g
    localparam logic [6:0] SEG_L     = 7'h47; // d e f
    localparam logic [6:0] SEG_O     = 7'h40; // a b c d e f
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_char_decode.sv
// 3-bit character code to 7-bit active-low segment pattern.
module seg7_char_decode
    import seg7_pkg::*;
(
    input  logic [2:0] code,
    output logic [6:0] seg
);

    // Pure lookup; anything outside H/E/L/O is blank.
    always_comb begin
        seg = SEG_BLANK;
        case (code)
            CHAR_H:  seg = SEG_H;
            CHAR_E:  seg = SEG_E;
            CHAR_L:  seg = SEG_L;
            CHAR_O:  seg = SEG_O;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_rotator.sv
// Multiplexed 7-segment driver: scans NUM_DIGITS digits, digit d shows
// channel (offset + d) mod NUM_CH. The offset follows sel (manual) or, when
// built with SEG7_ROTATE_EN, steps every ROT_TICKS cycles in rotate mode.
module seg7_scan_rotator
    import seg7_pkg::*;
#(
    parameter int NUM_CH     = 5,
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_TICKS = 50000,
    parameter int ROT_TICKS  = 25000000
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [3*NUM_CH-1:0]       ch_data,
    input  logic [$clog2(NUM_CH)-1:0] sel,
    input  logic                      rotate,
    input  logic                      pause,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     an
);

    localparam int CW = $clog2(NUM_CH);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SW = $clog2(SCAN_TICKS);

    logic [CW-1:0] offset;
    logic [CW-1:0] sel_safe;
    logic [CW-1:0] ch_idx;
    logic [CW:0]   idx_sum;
    logic [DW-1:0] digit;
    logic [SW-1:0] scan_cnt;
    logic [2:0]    ch_code [NUM_CH];
    logic [6:0]    pattern;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign ch_code[k] = ch_data[3*k +: 3];
    end

    // Out-of-range sel falls back to channel 0.
    assign sel_safe = ({1'b0, sel} >= (CW+1)'(NUM_CH)) ? '0 : sel;

    // offset < NUM_CH and digit < NUM_CH, so one conditional subtract wraps.
    assign idx_sum = {1'b0, offset} + (CW+1)'(digit);
    assign ch_idx  = (idx_sum >= (CW+1)'(NUM_CH)) ? CW'(idx_sum - (CW+1)'(NUM_CH))
                                                  : idx_sum[CW-1:0];

    seg7_char_decode u_dec (
        .code (ch_code[ch_idx]),
        .seg  (pattern)
    );

    // Scan timer: hold each digit for SCAN_TICKS cycles, then advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            digit    <= '0;
        end else if (scan_cnt == SW'(SCAN_TICKS - 1)) begin
            scan_cnt <= '0;
            digit    <= (digit == DW'(NUM_DIGITS - 1)) ? '0 : digit + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

`ifdef SEG7_ROTATE_EN
    localparam int RW = $clog2(ROT_TICKS);
    logic [RW-1:0] rot_cnt;

    // Offset: manual mode tracks sel and parks the timer at 0, so entering
    // rotate mode always starts a fresh ROT_TICKS interval from the current offset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset  <= '0;
            rot_cnt <= '0;
        end else if (!rotate) begin
            offset  <= sel_safe;
            rot_cnt <= '0;
        end else if (!pause) begin
            if (rot_cnt == RW'(ROT_TICKS - 1)) begin
                rot_cnt <= '0;
                offset  <= (offset == CW'(NUM_CH - 1)) ? '0 : offset + 1'b1;
            end else begin
                rot_cnt <= rot_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_ctrl;
    assign unused_ctrl = rotate ^ pause;

    // Offset: permanently manual, reloads sel every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) offset <= '0;
        else        offset <= sel_safe;
    end
`endif

    // Registered outputs from the current digit/offset; one-hot active-low enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_BLANK;
            an  <= '1;
        end else begin
            seg <= pattern;
            an  <= ~(NUM_DIGITS'(1) << digit);
        end
    end

endmodule
